bt_halfpel_window: RTL and testbench



---
 rtl/sgbm_pkg.sv | 13 +
 rtl/bt_halfpel_avg.sv | 27 ++
 rtl/bt_halfpel_window.sv | 152 +++++++++++++++
 tb/tb_bt_halfpel_window.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sgbm_pkg.sv
// Shared SGBM definitions: BT window FSM states and default datapath widths.
package sgbm_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } bt_win_state_t;

  localparam int BT_PIX_W = 8;
  localparam int BT_COL_W = 11;

endpackage

// File: rtl/bt_halfpel_avg.sv
// Combinational two-input half-pel average; rounds half up when
// BT_HALFPEL_ROUND_EN is defined, otherwise truncates.
module bt_halfpel_avg
  import sgbm_pkg::*;
#(
  parameter int Width = BT_PIX_W
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] avg_o
);

  // One guard bit keeps the carry so the halved result always fits Width.
  function automatic logic [Width-1:0] half_sum(input logic [Width-1:0] a,
                                                input logic [Width-1:0] b);
    logic [Width:0] sum;
`ifdef BT_HALFPEL_ROUND_EN
    sum = {1'b0, a} + {1'b0, b} + (Width+1)'(1);
`else
    sum = {1'b0, a} + {1'b0, b};
`endif
    return sum[Width:1];
  endfunction

  assign avg_o = half_sum(a_i, b_i);

endmodule

// File: rtl/bt_halfpel_window.sv
// BT half-pel window: emits (left half-pel, centre, right half-pel) per pixel
// with edge replication at line borders. Optional rounding: BT_HALFPEL_ROUND_EN.
module bt_halfpel_window
  import sgbm_pkg::*;
#(
  parameter int Width    = BT_PIX_W,
  parameter int ColWidth = BT_COL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [Width-1:0]    i_pixel,
  input  logic                i_eol,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [Width-1:0]    o_d0,
  output logic [Width-1:0]    o_d1,
  output logic [Width-1:0]    o_d2,
  output logic [ColWidth-1:0] o_col,
  output logic                o_eol
);

  bt_win_state_t         state_q, state_d;
  logic [Width-1:0]      prev_q, prev_d;
  logic [Width-1:0]      cur_q, cur_d;
  logic [ColWidth-1:0]   col_q, col_d;

  logic                  vld_q, vld_d;
  logic [Width-1:0]      d0_q, d0_d;
  logic [Width-1:0]      d1_q, d1_d;
  logic [Width-1:0]      d2_q, d2_d;
  logic [ColWidth-1:0]   ocol_q, ocol_d;
  logic                  oeol_q, oeol_d;

  logic                  slot_free;
  logic                  accept;
  logic [Width-1:0]      avg_left;
  logic [Width-1:0]      avg_right;

  bt_halfpel_avg #(.Width(Width)) u_avg_left (
    .a_i   (prev_q),
    .b_i   (cur_q),
    .avg_o (avg_left)
  );

  bt_halfpel_avg #(.Width(Width)) u_avg_right (
    .a_i   (cur_q),
    .b_i   (i_pixel),
    .avg_o (avg_right)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      prev_q  <= '0;
      cur_q   <= '0;
      col_q   <= '0;
      vld_q   <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      ocol_q  <= '0;
      oeol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      col_q   <= col_d;
      vld_q   <= vld_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ocol_q  <= ocol_d;
      oeol_q  <= oeol_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    col_d   = col_q;
    vld_d   = vld_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    ocol_d  = ocol_q;
    oeol_d  = oeol_q;
    // A drained output slot empties unless a new triplet is loaded below.
    if (slot_free) vld_d = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          if (i_eol) begin
            vld_d  = 1'b1;
            d0_d   = i_pixel;
            d1_d   = i_pixel;
            d2_d   = i_pixel;
            ocol_d = '0;
            oeol_d = 1'b1;
          end else begin
            prev_d  = i_pixel;
            cur_d   = i_pixel;
            col_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (accept) begin
          vld_d  = 1'b1;
          d0_d   = avg_left;
          d1_d   = cur_q;
          d2_d   = avg_right;
          ocol_d = col_q;
          oeol_d = 1'b0;
          prev_d = cur_q;
          cur_d  = i_pixel;
          col_d  = col_q + ColWidth'(1);
          if (i_eol) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Right border: the last pixel is replicated as its own neighbour.
        if (slot_free) begin
          vld_d   = 1'b1;
          d0_d    = avg_left;
          d1_d    = cur_q;
          d2_d    = cur_q;
          ocol_d  = col_q;
          oeol_d  = 1'b1;
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    slot_free = ~vld_q | i_ready;
    o_ready   = slot_free && (state_q != S_FLUSH);
    accept    = i_valid && o_ready;
    o_valid   = vld_q;
    o_d0      = d0_q;
    o_d1      = d1_q;
    o_d2      = d2_q;
    o_col     = ocol_q;
    o_eol     = oeol_q;
  end

endmodule

// File: tb/tb_bt_halfpel_window.sv
// Directed and randomized self-checking bench for bt_halfpel_window.
module tb_bt_halfpel_window;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_pixel;
  logic        i_eol;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_d0;
  logic [7:0]  o_d1;
  logic [7:0]  o_d2;
  logic [10:0] o_col;
  logic        o_eol;

  int vectors;
  int miscompares;

`ifdef BT_HALFPEL_ROUND_EN
  localparam int H_0_255   = 128;
  localparam int H_255_254 = 255;
`else
  localparam int H_0_255   = 127;
  localparam int H_255_254 = 254;
`endif

  typedef struct {
    logic [7:0] p;
    logic       e;
  } pix_t;

  pix_t        inq[$];
  logic [36:0] exq[$];

  bt_halfpel_window dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_pixel (i_pixel),
    .i_eol   (i_eol),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_d0    (o_d0),
    .o_d1    (o_d1),
    .o_d2    (o_d2),
    .o_col   (o_col),
    .o_eol   (o_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int avg(input int a, input int b);
`ifdef BT_HALFPEL_ROUND_EN
    return (a + b + 1) / 2;
`else
    return (a + b) / 2;
`endif
  endfunction

  function automatic logic [36:0] trip(input int d0, input int d1, input int d2,
                                       input int col, input int eol);
    return {1'b1, 8'(d0), 8'(d1), 8'(d2), 11'(col), 1'(eol)};
  endfunction

  function automatic logic [36:0] obs_out();
    return {o_valid, o_d0, o_d1, o_d2, o_col, o_eol};
  endfunction

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int p, input logic e);
    i_valid = v;
    i_pixel = 8'(p);
    i_eol   = e;
  endtask

  initial begin
    int          budget;
    int          eol_seen;
    int          n;
    int          l;
    int          r;
    logic [7:0]  px[64];
    logic [36:0] expv;
    pix_t        pe;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    i_ready     = 1'b1;
    drive(1'b0, 0, 1'b0);

    // Reset state
    #12;
    chk("rst_out", obs_out(), 37'd0);
    chk("rst_ready", 37'(o_ready), 37'd1);
    #10 rst_n = 1'b1;
    tick();

    // Line [10,20,40,30]
    drive(1'b1, 10, 1'b0); tick();
    chk("l1_prime", 37'(o_valid), 37'd0);
    drive(1'b1, 20, 1'b0); tick();
    chk("l1_c0", obs_out(), trip(10, 10, 15, 0, 0));
    drive(1'b1, 40, 1'b0); tick();
    chk("l1_c1", obs_out(), trip(15, 20, 30, 1, 0));
    drive(1'b1, 30, 1'b1); tick();
    chk("l1_c2", obs_out(), trip(30, 40, 35, 2, 0));
    chk("l1_flush_ready", 37'(o_ready), 37'd0);
    drive(1'b0, 0, 1'b0); tick();
    chk("l1_c3", obs_out(), trip(35, 30, 30, 3, 1));
    chk("l1_ready_back", 37'(o_ready), 37'd1);
    tick();
    chk("l1_idle", 37'(o_valid), 37'd0);

    // Single-pixel line
    drive(1'b1, 77, 1'b1); tick();
    chk("l2_single", obs_out(), trip(77, 77, 77, 0, 1));
    drive(1'b0, 0, 1'b0); tick();
    chk("l2_idle", 37'(o_valid), 37'd0);
    chk("l2_ready", 37'(o_ready), 37'd1);

    // Line [0,255,254] with a 3-cycle downstream stall
    drive(1'b1, 0, 1'b0); tick();
    drive(1'b1, 255, 1'b0); tick();
    chk("l3_c0", obs_out(), trip(0, 0, H_0_255, 0, 0));
    i_ready = 1'b0;
    drive(1'b1, 254, 1'b1);
    #1;
    chk("l3_stall_ready", 37'(o_ready), 37'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("l3_stall_out", obs_out(), trip(0, 0, H_0_255, 0, 0));
      chk("l3_stall_rdy", 37'(o_ready), 37'd0);
    end
    i_ready = 1'b1;
    tick();
    chk("l3_c1", obs_out(), trip(H_0_255, 255, H_255_254, 1, 0));
    drive(1'b0, 0, 1'b0); tick();
    chk("l3_c2", obs_out(), trip(H_255_254, 254, 254, 2, 1));
    tick();

    // Back-to-back lines [1,3,5][7,9,11]
    drive(1'b1, 1, 1'b0); tick();
    drive(1'b1, 3, 1'b0); tick();
    chk("l4_a0", obs_out(), trip(1, 1, 2, 0, 0));
    drive(1'b1, 5, 1'b1); tick();
    chk("l4_a1", obs_out(), trip(2, 3, 4, 1, 0));
    chk("l4_flush_ready", 37'(o_ready), 37'd0);
    drive(1'b1, 7, 1'b0); tick();
    chk("l4_a2", obs_out(), trip(4, 5, 5, 2, 1));
    chk("l4_ready_back", 37'(o_ready), 37'd1);
    tick();
    chk("l4_bubble", 37'(o_valid), 37'd0);
    drive(1'b1, 9, 1'b0); tick();
    chk("l4_b0", obs_out(), trip(7, 7, 8, 0, 0));
    drive(1'b1, 11, 1'b1); tick();
    chk("l4_b1", obs_out(), trip(8, 9, 10, 1, 0));
    drive(1'b0, 0, 1'b0); tick();
    chk("l4_b2", obs_out(), trip(10, 11, 11, 2, 1));
    tick();

    // Reset mid-line
    drive(1'b1, 50, 1'b0); tick();
    drive(1'b1, 60, 1'b0); tick();
    chk("l5_pre", obs_out(), trip(50, 50, 55, 0, 0));
    drive(1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("l5_rst_out", obs_out(), 37'd0);
    #2 rst_n = 1'b1;
    tick();
    drive(1'b1, 90, 1'b0); tick();
    chk("l5_prime", 37'(o_valid), 37'd0);
    drive(1'b1, 100, 1'b1); tick();
    chk("l5_c0", obs_out(), trip(90, 90, 95, 0, 0));
    drive(1'b0, 0, 1'b0); tick();
    chk("l5_c1", obs_out(), trip(95, 100, 100, 1, 1));
    tick();

    // Random traffic against a line-level BT model
    for (int ln = 0; ln < 200; ln++) begin
      n = $urandom_range(1, 64);
      for (int x = 0; x < n; x++) begin
        case ($urandom_range(0, 5))
          0:       px[x] = 8'd0;
          1:       px[x] = 8'd255;
          default: px[x] = 8'($urandom);
        endcase
      end
      for (int x = 0; x < n; x++) begin
        l = (x == 0) ? int'(px[x]) : int'(px[x-1]);
        r = (x == n - 1) ? int'(px[x]) : int'(px[x+1]);
        pe.p = px[x];
        pe.e = (x == n - 1);
        inq.push_back(pe);
        exq.push_back(trip(avg(l, int'(px[x])), int'(px[x]), avg(int'(px[x]), r),
                           x, int'(x == n - 1)));
      end
    end

    budget   = 0;
    eol_seen = 0;
    while ((exq.size() > 0 || inq.size() > 0) && budget < 60000) begin
      if (inq.size() > 0 && $urandom_range(0, 3) != 0) begin
        i_valid = 1'b1;
        i_pixel = inq[0].p;
        i_eol   = inq[0].e;
      end else begin
        i_valid = 1'b0;
        i_pixel = 8'($urandom);
        i_eol   = 1'($urandom);
      end
      i_ready = ($urandom_range(0, 3) != 0);
      #3;
      if (o_valid && i_ready) begin
        if (exq.size() == 0) begin
          chk("rnd_extra", obs_out(), 37'd0);
        end else begin
          expv = exq.pop_front();
          chk("rnd_trip", obs_out(), expv);
          if (o_eol) eol_seen++;
        end
      end
      if (i_valid && o_ready) pe = inq.pop_front();
      @(posedge clk);
      #1;
      budget++;
    end
    chk("rnd_budget", 37'(budget < 60000), 37'd1);
    chk("rnd_eol_count", 37'(eol_seen), 37'd200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
